// File: rtl/program_loader.sv
// Boot loader: takes a length-prefixed little-endian byte stream, writes the words into program
// memory, then releases the CPU pipeline reset so fetch starts at address 0.
module program_loader #(
  parameter int MEM_WORDS      = 8,
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           rx_valid,
  input  logic [7:0]                     rx_data,
  output logic                           rx_ready,
  output logic [ADDR_WIDTH-1:0]          mem_address,
  output logic                           mem_write_enable,
  output logic [31:0]                    mem_write_data,
  output logic                           cpu_reset_n,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [$clog2(MEM_WORDS+1)-1:0] words_loaded,
  output logic [2:0]                     fsm_state
);

  localparam int CW = $clog2(MEM_WORDS + 1);
  localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_RUN    = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   n_words;
  logic [1:0]      byte_idx;
  logic [IW-1:0]   word_idx;
  logic [23:0]     word_buf;
  logic [TW-1:0]   idle_cnt;
  logic            accept;
  logic            header_ok;
  logic            last_word;
  logic            timed_out;

  assign fsm_state = state;

  // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready; rx_ready is registered.
  always_comb begin
    accept     = rx_valid && rx_ready;
    header_ok  = (rx_data != 8'd0) && (rx_data <= 8'(MEM_WORDS));
    last_word  = (CW'(word_idx) + CW'(1)) == n_words;
    timed_out  = !accept && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    state_next = state;
    case (state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) state_next = S_HEADER;
      end
      S_HEADER: begin
        if (accept)         state_next = header_ok ? S_DATA : S_ERROR;
        else if (timed_out) state_next = S_ERROR;
      end
      S_DATA: begin
        if (accept && byte_idx == 2'd3) state_next = S_WRITE;
        else if (timed_out)             state_next = S_ERROR;
      end
      S_WRITE: begin
        state_next = last_word ? S_RUN : S_DATA;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from state_next so they appear as flops aligned with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      rx_ready         <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      cpu_reset_n      <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      words_loaded     <= '0;
      n_words          <= '0;
      byte_idx         <= '0;
      word_idx         <= '0;
      word_buf         <= '0;
      idle_cnt         <= '0;
    end else begin
      state            <= state_next;
      rx_ready         <= (state_next == S_HEADER) || (state_next == S_DATA);
      busy             <= (state_next == S_HEADER) || (state_next == S_DATA) ||
                          (state_next == S_WRITE);
      mem_write_enable <= (state_next == S_WRITE);
      cpu_reset_n      <= (state_next == S_RUN);
      done             <= (state_next == S_RUN);
      error            <= (state_next == S_ERROR);

      case (state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (start) idle_cnt <= '0;
        end
        S_HEADER: begin
          if (accept) begin
            idle_cnt <= '0;
            if (header_ok) begin
              n_words      <= rx_data[CW-1:0];
              byte_idx     <= '0;
              word_idx     <= '0;
              words_loaded <= '0;
            end
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        S_DATA: begin
          if (accept) begin
            idle_cnt <= '0;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                // Fourth byte goes straight to the write register alongside the buffered lanes.
                mem_write_data <= {rx_data, word_buf};
                mem_address    <= ADDR_WIDTH'({word_idx, 2'b00});
                words_loaded   <= words_loaded + CW'(1);
              end
            endcase
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        S_WRITE: begin
          if (!last_word) begin
            word_idx <= word_idx + IW'(1);
            byte_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected memory writes are queued by the stimulus and
// popped by an independent write monitor; session-level outputs are checked inline.
module tb_program_loader;
  localparam int MW = 8;
  localparam int AW = 5;
  localparam int TO = 20;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic [AW-1:0] mem_address;
  logic          mem_write_enable;
  logic [31:0]   mem_write_data;
  logic          cpu_reset_n;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] words_loaded;
  logic [2:0]    fsm_state;

  int checks   = 0;
  int failures = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] exp_item;
  logic [31:0]    mem_model[MW];
  logic           prev_we = 1'b0;
  logic [7:0]     two_word[9] = '{8'h02, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};

  program_loader #(.MEM_WORDS(MW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data), .cpu_reset_n(cpu_reset_n), .busy(busy), .done(done),
    .error(error), .words_loaded(words_loaded), .fsm_state(fsm_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got no completion want completion within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Write monitor / scoreboard
  always @(negedge clk) begin
    if (mem_write_enable) begin
      chk("wr_single_cycle", prev_we, 0);
      chk("wr_rx_ready_low", rx_ready, 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h want no write",
                 mem_address, mem_write_data);
      end else begin
        exp_item = exp_q.pop_front();
        chk("wr_addr_data", {mem_address, mem_write_data}, exp_item);
      end
      mem_model[mem_address[AW-1:2]] = mem_write_data;
    end
    prev_we = mem_write_enable;
  end

  // Driver tasks (all start and end 1 time unit after a rising edge)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gaps, input bit pulse_start);
    bit ok;
    for (int i = 0; i < gaps; i++) begin
      rx_valid = 1'b0;
      start    = pulse_start && (i == 0);
      tick();
      start    = 1'b0;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (rx_ready) ok = 1'b1;
      tick();
    end
    chk("rx_accept", ok, 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_mem_we", mem_write_enable, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_data", mem_write_data, 0);
    chk("rst_cpu_reset_n", cpu_reset_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_words_loaded", words_loaded, 0);
    chk("rst_state_idle", fsm_state, 0);
  endtask

  task automatic check_release(input string tag, input int nwords);
    rx_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_held_in_write"}, cpu_reset_n, 0);
    @(negedge clk);
    chk({tag, "_cpu_released"}, cpu_reset_n, 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_words_loaded"}, words_loaded, nwords);
    tick();
  endtask

  // Main sequence
  initial begin
    reset = 1'b1; start = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    for (int i = 0; i < MW; i++) mem_model[i] = 32'h0;

    repeat (2) tick();
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0; start = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_after_reset", fsm_state, 0);
    tick();

    // Two-word load, rx_valid held high
    start_pulse();
    exp_q.push_back({5'd0, 32'h00100093});
    exp_q.push_back({5'd4, 32'h00200113});
    for (int i = 0; i < 9; i++) send_byte(two_word[i], 0, 1'b0);
    check_release("load2", 2);

    // Reload from RUN with gaps and ignored start pulses
    start_pulse();
    @(negedge clk);
    chk("reload_cpu_reset_low", cpu_reset_n, 0);
    chk("reload_busy", busy, 1);
    tick();
    exp_q.push_back({5'd0, 32'h00100093});
    exp_q.push_back({5'd4, 32'h00200113});
    for (int i = 0; i < 9; i++) send_byte(two_word[i], 1, (i == 3) || (i == 7));
    check_release("gaps", 2);
    repeat (4) tick();
    @(negedge clk);
    chk("no_extra_session_done", done, 1);
    chk("no_extra_session_busy", busy, 0);
    tick();

    // Bad headers
    for (int h = 0; h < 2; h++) begin
      start_pulse();
      send_byte((h == 0) ? 8'h00 : 8'h09, 0, 1'b0);
      rx_valid = 1'b0;
      @(negedge clk);
      chk("badhdr_error", error, 1);
      chk("badhdr_cpu_reset_n", cpu_reset_n, 0);
      chk("badhdr_rx_ready", rx_ready, 0);
      tick();
      start_pulse();
      @(negedge clk);
      chk("badhdr_error_cleared", error, 0);
      chk("badhdr_restart_busy", busy, 1);
      tick();
    end

    // Timeout after two of four bytes (already in HEADER)
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    rx_valid = 1'b0;
    repeat (TO - 1) tick();
    @(negedge clk);
    chk("timeout_not_early", error, 0);
    tick();
    @(negedge clk);
    chk("timeout_error", error, 1);
    chk("timeout_cpu_reset_n", cpu_reset_n, 0);
    chk("timeout_busy", busy, 0);
    tick();

    // Accept on the limiting cycle wins
    start_pulse();
    send_byte(8'h01, 0, 1'b0);
    exp_q.push_back({5'd0, 32'hDDCCBBAA});
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    send_byte(8'hCC, TO - 1, 1'b0);
    send_byte(8'hDD, 0, 1'b0);
    check_release("limit_accept", 1);
    chk("limit_accept_no_error", error, 0);

    // Reload then reset mid-DATA
    start_pulse();
    @(negedge clk);
    chk("midrst_cpu_reset_low", cpu_reset_n, 0);
    tick();
    send_byte(8'h02, 0, 1'b0);
    exp_q.push_back({5'd0, 32'h44332211});
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    send_byte(8'h33, 0, 1'b0);
    send_byte(8'h44, 0, 1'b0);
    send_byte(8'h55, 0, 1'b0);
    send_byte(8'h66, 0, 1'b0);
    rx_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    chk("mem0_kept", mem_model[0], 32'h44332211);
    chk("mem1_kept", mem_model[1], 32'h00200113);
    repeat (3) tick();
    chk("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
